// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - state encoding, parity constants and default widths shared by uart_tx and uart_rx
package uart_pkg;
  localparam int DEFAULT_DATA_WIDTH     = 8;
  localparam int DEFAULT_PRESCALE_WIDTH = 6;

  localparam logic PARITY_ODD  = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;
endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit cycle counter; bit_tick marks the last cycle of each bit period
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int PERIOD_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [PERIOD_WIDTH-1:0] period,
  output logic                    bit_tick
);

  logic [PERIOD_WIDTH-1:0] count;
  logic [PERIOD_WIDTH-1:0] last;

  // A zero period is treated as one cycle per bit.
  assign last     = (period == '0) ? '0 : period - 1'b1;
  assign bit_tick = (count == last) && !load;

  always_ff @(posedge clk) begin
    if (rst || load || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, one stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      parity_en,
  input  logic                      parity_type,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      s_data,
  output logic                      busy,
  output logic                      tx_done
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_e               state, state_next;
  logic [DATA_WIDTH-1:0]     data_reg;
  logic                      par_en_reg;
  logic                      par_type_reg;
  logic [PRESCALE_WIDTH-1:0] presc_reg;
  logic [IDX_W-1:0]          bit_idx, bit_idx_next;
  logic                      s_data_next, busy_next, done_next;
  logic                      accept;
  logic                      bit_tick;
  logic                      parity_bit;

  assign parity_bit = (par_type_reg == PARITY_EVEN) ? ^data_reg : ~^data_reg;

  // Held in load while idle so the first bit period starts counting at the accepting edge.
  uart_bit_timer #(
    .PERIOD_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (state == IDLE),
    .period  (presc_reg),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_next   = state;
    s_data_next  = s_data;
    busy_next    = busy;
    done_next    = 1'b0;
    bit_idx_next = bit_idx;
    accept       = 1'b0;
    unique case (state)
      IDLE: begin
        s_data_next = 1'b1;
        busy_next   = 1'b0;
        if (data_valid) begin
          accept      = 1'b1;
          state_next  = START;
          s_data_next = 1'b0;
          busy_next   = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_next   = DATA;
          bit_idx_next = '0;
          s_data_next  = data_reg[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == LAST_IDX) begin
            state_next  = par_en_reg ? PARITY : STOP;
            s_data_next = par_en_reg ? parity_bit : 1'b1;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
            s_data_next  = data_reg[bit_idx_next];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_next  = STOP;
          s_data_next = 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_next  = IDLE;
          busy_next   = 1'b0;
          done_next   = 1'b1;
          s_data_next = 1'b1;
        end
      end
      default: begin
        state_next  = IDLE;
        s_data_next = 1'b1;
        busy_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      s_data       <= 1'b1;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
      bit_idx      <= '0;
      data_reg     <= '0;
      par_en_reg   <= 1'b0;
      par_type_reg <= 1'b0;
      presc_reg    <= '0;
    end else begin
      state   <= state_next;
      s_data  <= s_data_next;
      busy    <= busy_next;
      tx_done <= done_next;
      bit_idx <= bit_idx_next;
      if (accept) begin
        data_reg     <= p_data;
        par_en_reg   <= parity_en;
        par_type_reg <= parity_type;
        presc_reg    <= prescale;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with a frame-level reference model
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_data = '0;
  logic       data_valid = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic [5:0] prescale = '0;
  logic       s_data, busy, tx_done;

  uart_tx dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .parity_en  (parity_en),
    .parity_type(parity_type),
    .prescale   (prescale),
    .s_data     (s_data),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          acc;
    int          p;
    int          total;
    int          abort_at;
    logic [11:0] bits;
  } frame_t;

  frame_t q[$];
  int     errors = 0;
  int     checks = 0;
  int     model_free = 0;
  int     last_acc = 0;
  bit     in_frame = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected line levels for one frame, one entry per bit period.
  function automatic frame_t build(input logic [7:0] d, input bit pe, input bit pt, input int pres);
    frame_t r;
    int n;
    r.bits = '0;
    r.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) r.bits[i+1] = d[i];
    n = 9;
    if (pe) begin
      r.bits[n] = pt ? ($countones(d) % 2 == 0) : ($countones(d) % 2 == 1);
      n++;
    end
    r.bits[n] = 1'b1;
    n++;
    r.p = (pres == 0) ? 1 : pres;
    r.total = n * r.p;
    r.abort_at = -1;
    r.acc = 0;
    return r;
  endfunction

  task automatic send(input logic [7:0] d, input bit pe, input bit pt, input int pres,
                      input bit keep, input int abort_at);
    frame_t r;
    int acc;
    p_data = d;
    parity_en = pe;
    parity_type = pt;
    prescale = 6'(pres);
    data_valid = 1'b1;
    acc = (cyc + 1 > model_free) ? cyc + 1 : model_free;
    r = build(d, pe, pt, pres);
    r.acc = acc;
    r.abort_at = abort_at;
    q.push_back(r);
    model_free = acc + r.total + 1;
    while (cyc < acc) begin
      @(posedge clk);
      #1;
    end
    if (!keep) data_valid = 1'b0;
    last_acc = acc;
  endtask

  task automatic perturb();
    p_data = 8'($urandom);
    parity_en = 1'($urandom);
    parity_type = 1'($urandom);
    prescale = 6'($urandom);
  endtask

  task automatic run_frame(input frame_t r);
    check("accept_cycle", cyc, r.acc);
    for (int i = 0; i < r.total; i++) begin
      if (i > 0) @(negedge clk);
      if (i == r.abort_at) begin
        check("abort_busy", busy, 0);
        check("abort_s_data", s_data, 1);
        check("abort_tx_done", tx_done, 0);
        return;
      end
      check("busy", busy, 1);
      check("s_data", s_data, r.bits[i / r.p]);
      check("tx_done_mid", tx_done, 0);
    end
    @(negedge clk);
    check("end_busy", busy, 0);
    check("done_pulse", tx_done, 1);
    check("stop_idle", s_data, 1);
  endtask

  initial begin : monitor
    frame_t r;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (busy !== 1'b1) begin
        check("idle_s_data", s_data, 1);
        check("idle_tx_done", tx_done, 0);
      end else if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: busy=%0b with no request pending at cycle %0d", busy, cyc);
      end else begin
        r = q.pop_front();
        in_frame = 1;
        run_frame(r);
        in_frame = 0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stimulus
    int acc;
    int k;
    step(3);
    check("reset_s_data", s_data, 1);
    check("reset_busy", busy, 0);
    check("reset_tx_done", tx_done, 0);
    rst = 1'b0;
    model_free = cyc + 1;
    step(2);

    send(8'hAA, 0, 0, 8, 0, -1);
    perturb();
    send(8'hAA, 1, 1, 8, 0, -1);
    perturb();
    send(8'h55, 1, 0, 8, 0, -1);
    perturb();

    send(8'hAA, 0, 0, 8, 1, -1);
    acc = last_acc;
    while (cyc < acc + 20) step(1);
    send(8'h0F, 0, 0, 8, 0, -1);
    perturb();

    send(8'h96, 0, 0, 0, 0, -1);
    perturb();

    send(8'h3C, 0, 0, 8, 0, -1);
    step(5);
    prescale = 6'd3;

    send(8'hC3, 1, 0, 8, 0, 30);
    acc = last_acc;
    while (cyc < acc + 29) step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    model_free = cyc + 1;
    step(3);

    p_data = 8'h81;
    rst = 1'b1;
    data_valid = 1'b1;
    step(1);
    rst = 1'b0;
    data_valid = 1'b0;
    model_free = cyc + 1;
    step(5);

    for (int n = 0; n < 8; n++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 5), 0, -1);
      perturb();
      step($urandom_range(0, 3));
    end

    k = 0;
    while ((q.size() != 0 || in_frame) && k < 3000) begin
      step(1);
      k++;
    end
    if (q.size() != 0 || in_frame) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d frames still expected at cycle %0d", q.size(), cyc);
    end
    step(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
